bsg_mesh_traffic_gen: RTL and testbench

//  Synthesizable packet source for one mesh tile; drives the proc (P) input side of bsg_mesh_router, directly or through its proc input fifo.

---
 rtl/bsg_mesh_traffic_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_bsg_mesh_traffic_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mesh_traffic_gen.sv
// bsg_mesh_traffic_gen
// Packet source for one mesh tile. It drives the proc-side input of a mesh
// router with {payload, dest_y, dest_x} packets over a ready/valid handshake.
// Destinations either sweep every tile in row-major order or come from a
// 16-bit Fibonacci LFSR. Out-of-range LFSR candidates cost one bubble cycle.
// v_o and data_o are registered, so there is no combinational path from
// ready_and_i to valid.
module bsg_mesh_traffic_gen #(
    parameter int x_cord_width_p = 2,
    parameter int y_cord_width_p = 2,
    parameter int data_width_p   = 4,
    parameter int num_tiles_x_p  = 4,
    parameter int num_tiles_y_p  = 4,
    parameter int count_width_p  = 16
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_n_i,
    input  logic [x_cord_width_p-1:0]                             my_x_i,
    input  logic [y_cord_width_p-1:0]                             my_y_i,
    input  logic                                                  start_i,
    input  logic                                                  rand_mode_i,
    input  logic [count_width_p-1:0]                              num_pkts_i,
    output logic                                                  v_o,
    output logic [data_width_p+y_cord_width_p+x_cord_width_p-1:0] data_o,
    input  logic                                                  ready_and_i,
    output logic                                                  busy_o,
    output logic                                                  done_o,
    output logic [count_width_p-1:0]                              sent_count_o
);

    localparam int XW  = x_cord_width_p;
    localparam int YW  = y_cord_width_p;
    localparam int DW  = data_width_p;
    localparam int CW  = count_width_p;
    localparam int PW  = DW + YW + XW;
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;

    // Last column/row index of the sweep; the sweep wraps after these.
    localparam logic [XW-1:0] X_LAST = XW'(num_tiles_x_p - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(num_tiles_y_p - 1);

    // Tile counts widened by one bit so that a full 2**width mesh is representable.
    localparam logic [XW1-1:0] NX_EXT = XW1'(num_tiles_x_p);
    localparam logic [YW1-1:0] NY_EXT = YW1'(num_tiles_y_p);

    localparam logic [15:0] LFSR_BASE = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One Fibonacci step: taps 16,14,13,11, shift left, feedback enters bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [CW-1:0]   r_num_pkts;
    logic            r_rand_mode;
    logic [CW-1:0]   r_sent_count;
    logic [XW-1:0]   r_dest_x;
    logic [YW-1:0]   r_dest_y;
    logic [15:0]     r_lfsr;
    logic            r_v;
    logic [PW-1:0]   r_data;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    state_t          w_state_next;
    logic [CW-1:0]   w_num_pkts_next;
    logic            w_rand_mode_next;
    logic [CW-1:0]   w_sent_count_next;
    logic [XW-1:0]   w_dest_x_next;
    logic [YW-1:0]   w_dest_y_next;
    logic [15:0]     w_lfsr_next;
    logic            w_v_next;
    logic [PW-1:0]   w_data_next;

    logic            w_start;
    logic            w_xfer;
    logic            w_last_xfer;
    logic [15:0]     w_seed;
    logic [XW-1:0]   w_cand_x;
    logic [YW-1:0]   w_cand_y;
    logic            w_cand_ok;
    logic [XW-1:0]   w_sel_x;
    logic [YW-1:0]   w_sel_y;
    logic [DW-1:0]   w_tile_id;
    logic [DW-1:0]   w_payload;

    // Per-tile seed; upper LFSR bits stay 0xAC so the seed is never zero.
    assign w_seed = LFSR_BASE ^ {{(16 - XW - YW){1'b0}}, my_y_i, my_x_i};

    // start_i only counts outside RUN; a transfer needs a registered valid.
    assign w_start     = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_xfer      = (r_state == S_RUN) && r_v && ready_and_i;
    assign w_last_xfer = w_xfer && ((r_sent_count + CW'(1)) == r_num_pkts);

    // Payload is computed directly at payload width: truncation commutes
    // with the XOR, and narrow counts are zero-extended by the cast.
    assign w_tile_id = DW'(my_y_i) * DW'(num_tiles_x_p) + DW'(my_x_i);
    assign w_payload = DW'(w_sent_count_next) ^ w_tile_id;

    // Random-mode candidate destination, taken from the LFSR value that
    // will be held next cycle.
    assign w_cand_x  = w_lfsr_next[XW-1:0];
    assign w_cand_y  = w_lfsr_next[XW +: YW];
    assign w_cand_ok = ({1'b0, w_cand_x} < NX_EXT) && ({1'b0, w_cand_y} < NY_EXT);

    assign w_sel_x = w_rand_mode_next ? w_cand_x : w_dest_x_next;
    assign w_sel_y = w_rand_mode_next ? w_cand_y : w_dest_y_next;

    // Valid for next cycle: always in sweep mode, only for in-range candidates
    // in random mode. Data is zeroed whenever it is not being offered.
    assign w_v_next    = (w_state_next == S_RUN) && (!w_rand_mode_next || w_cand_ok);
    assign w_data_next = w_v_next ? {w_payload, w_sel_y, w_sel_x} : '0;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: a zero-length run goes straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = (num_pkts_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_xfer) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath next values: latch on start, advance on transfer or bubble.
    always_comb begin
        w_num_pkts_next   = r_num_pkts;
        w_rand_mode_next  = r_rand_mode;
        w_sent_count_next = r_sent_count;
        w_dest_x_next     = r_dest_x;
        w_dest_y_next     = r_dest_y;
        w_lfsr_next       = r_lfsr;
        if (w_start) begin
            w_num_pkts_next   = num_pkts_i;
            w_rand_mode_next  = rand_mode_i;
            w_sent_count_next = '0;
            w_dest_x_next     = '0;
            w_dest_y_next     = '0;
            w_lfsr_next       = w_seed;
        end else if (r_state == S_RUN) begin
            if (w_xfer) begin
                if (r_sent_count != '1) begin
                    w_sent_count_next = r_sent_count + CW'(1);
                end
                if (r_rand_mode) begin
                    w_lfsr_next = lfsr_step(r_lfsr);
                end else if (r_dest_x == X_LAST) begin
                    w_dest_x_next = '0;
                    w_dest_y_next = (r_dest_y == Y_LAST) ? '0 : r_dest_y + YW'(1);
                end else begin
                    w_dest_x_next = r_dest_x + XW'(1);
                end
            end else if (r_rand_mode && !r_v) begin
                // Bubble: the current candidate was out of range, try the next one.
                w_lfsr_next = lfsr_step(r_lfsr);
            end
        end else if (r_state == S_IDLE) begin
            // The reset value cannot depend on the tile inputs, so the
            // tile-specific seed is loaded on every idle cycle instead.
            w_lfsr_next = w_seed;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_num_pkts   <= '0;
            r_rand_mode  <= 1'b0;
            r_sent_count <= '0;
            r_dest_x     <= '0;
            r_dest_y     <= '0;
            r_lfsr       <= LFSR_BASE;
            r_v          <= 1'b0;
            r_data       <= '0;
        end else begin
            r_num_pkts   <= w_num_pkts_next;
            r_rand_mode  <= w_rand_mode_next;
            r_sent_count <= w_sent_count_next;
            r_dest_x     <= w_dest_x_next;
            r_dest_y     <= w_dest_y_next;
            r_lfsr       <= w_lfsr_next;
            r_v          <= w_v_next;
            r_data       <= w_data_next;
        end
    end

    // Outputs: status decoded from the state register, handshake from registers.
    always_comb begin
        busy_o       = (r_state == S_RUN);
        done_o       = (r_state == S_DONE);
        v_o          = r_v;
        data_o       = r_data;
        sent_count_o = r_sent_count;
    end

endmodule

// File: tb/tb_bsg_mesh_traffic_gen.sv
// Directed bench for bsg_mesh_traffic_gen: a vector table for sweep runs,
// stalls, zero-length runs and held start; hand sequences for mid-run reset
// and a 3x3 random-mode run checked against an LFSR reference model.
module tb_bsg_mesh_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default 4x4 instance
    logic        rst_n, start, rmode, ready, v, busy, done;
    logic [1:0]  my_x, my_y;
    logic [15:0] num, sent;
    logic [7:0]  data;

    // 3x3 instance for random mode
    logic        rst3_n, start3, rmode3, ready3, v3, busy3, done3;
    logic [1:0]  my_x3, my_y3;
    logic [15:0] num3, sent3;
    logic [7:0]  data3;

    bsg_mesh_traffic_gen dut (
        .clk_i(clk), .reset_n_i(rst_n), .my_x_i(my_x), .my_y_i(my_y),
        .start_i(start), .rand_mode_i(rmode), .num_pkts_i(num),
        .v_o(v), .data_o(data), .ready_and_i(ready),
        .busy_o(busy), .done_o(done), .sent_count_o(sent)
    );

    bsg_mesh_traffic_gen #(.num_tiles_x_p(3), .num_tiles_y_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(rst3_n), .my_x_i(my_x3), .my_y_i(my_y3),
        .start_i(start3), .rand_mode_i(rmode3), .num_pkts_i(num3),
        .v_o(v3), .data_o(data3), .ready_and_i(ready3),
        .busy_o(busy3), .done_o(done3), .sent_count_o(sent3)
    );

    typedef struct {
        logic        start;
        logic [15:0] num;
        logic        ready;
        logic        ev;
        logic [7:0]  edata;
        logic        ebusy;
        logic        edone;
        logic [15:0] esent;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input int n, input logic rdy, input logic ev,
                       input logic [7:0] ed, input logic eb, input logic edn, input int es);
        vec_t t;
        t.start = s; t.num = 16'(n); t.ready = rdy; t.ev = ev;
        t.edata = ed; t.ebusy = eb; t.edone = edn; t.esent = 16'(es);
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    initial begin
        logic [15:0] m_lfsr;
        int          m_count;
        int          bubbles;
        int          cyc;
        logic        exp_v;
        logic        rdy;
        logic [3:0]  pay;

        // Tile (x=1,y=2) on 4x4: tile_id 9, payload n^9.
        // Table fields: start, num, ready | v, data, busy, done, sent
        // Sweep run of 5 with constant ready
        add(1, 5, 1,  0, 8'h00, 0, 0, 0);
        add(0, 5, 1,  1, 8'h90, 1, 0, 0);
        add(0, 5, 1,  1, 8'h81, 1, 0, 1);
        add(0, 5, 1,  1, 8'hB2, 1, 0, 2);
        add(0, 5, 1,  1, 8'hA3, 1, 0, 3);
        add(0, 5, 1,  1, 8'hD4, 1, 0, 4);
        add(0, 5, 1,  0, 8'h00, 0, 1, 5);
        // Same run with ready 1-0-0-1 repeating
        add(1, 5, 1,  0, 8'h00, 0, 1, 5);
        add(0, 5, 1,  1, 8'h90, 1, 0, 0);
        add(0, 5, 0,  1, 8'h81, 1, 0, 1);
        add(0, 5, 0,  1, 8'h81, 1, 0, 1);
        add(0, 5, 1,  1, 8'h81, 1, 0, 1);
        add(0, 5, 1,  1, 8'hB2, 1, 0, 2);
        add(0, 5, 0,  1, 8'hA3, 1, 0, 3);
        add(0, 5, 0,  1, 8'hA3, 1, 0, 3);
        add(0, 5, 1,  1, 8'hA3, 1, 0, 3);
        add(0, 5, 1,  1, 8'hD4, 1, 0, 4);
        add(0, 5, 1,  0, 8'h00, 0, 1, 5);
        // Zero-length run, then a run of 2
        add(1, 0, 1,  0, 8'h00, 0, 1, 5);
        add(1, 2, 1,  0, 8'h00, 0, 1, 0);
        add(0, 2, 1,  1, 8'h90, 1, 0, 0);
        add(0, 2, 1,  1, 8'h81, 1, 0, 1);
        add(0, 2, 1,  0, 8'h00, 0, 1, 2);
        // start held high through RUN: ignored there, restarts from DONE
        add(1, 2, 1,  0, 8'h00, 0, 1, 2);
        add(1, 2, 1,  1, 8'h90, 1, 0, 0);
        add(1, 2, 1,  1, 8'h81, 1, 0, 1);
        add(1, 2, 1,  0, 8'h00, 0, 1, 2);
        add(1, 2, 1,  1, 8'h90, 1, 0, 0);
        add(1, 2, 1,  1, 8'h81, 1, 0, 1);
        add(0, 2, 1,  0, 8'h00, 0, 1, 2);
        add(0, 2, 1,  0, 8'h00, 0, 1, 2);

        rst_n = 1'b0; start = 1'b0; rmode = 1'b0; num = '0; ready = 1'b0;
        my_x = 2'd1; my_y = 2'd2;
        rst3_n = 1'b0; start3 = 1'b0; rmode3 = 1'b0; num3 = '0; ready3 = 1'b0;
        my_x3 = 2'd2; my_y3 = 2'd1;

        repeat (2) @(negedge clk);
        chk("reset_v", {31'd0, v}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sent", {16'd0, sent}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1; rst3_n = 1'b1;

        // Table-driven phase: check registered outputs, then drive this cycle's inputs
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_v", i), {31'd0, v}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].ebusy});
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].edone});
            chk($sformatf("vec%0d_sent", i), {16'd0, sent}, {16'd0, vecs[i].esent});
            if (vecs[i].ev)
                chk($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vecs[i].edata});
            start = vecs[i].start; num = vecs[i].num; ready = vecs[i].ready; rmode = 1'b0;
        end

        // Mid-run reset: run of 10, reset while packet 3 is offered
        @(negedge clk);
        start = 1'b1; num = 16'd10; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_sent", {16'd0, sent}, 32'd3);
        chk("rst_mid_data", {24'd0, data}, 32'hA3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_v", {31'd0, v}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_sent", {16'd0, sent}, 32'd0);
        chk("rst_async_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_idle_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_idle_done", {31'd0, done}, 32'd0);
        start = 1'b1; num = 16'd10;
        @(negedge clk);
        start = 1'b0;
        chk("rst_restart_v", {31'd0, v}, 32'd1);
        chk("rst_restart_data", {24'd0, data}, 32'h90);
        chk("rst_restart_sent", {16'd0, sent}, 32'd0);

        // Random mode on 3x3, tile (2,1): tile_id 5, seed 0xACE1^0x06
        @(negedge clk);
        start3 = 1'b1; rmode3 = 1'b1; num3 = 16'd100; ready3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        m_lfsr = 16'hACE1 ^ 16'h0006;
        m_count = 0; bubbles = 0; cyc = 0;
        while (m_count < 100 && cyc < 3000) begin
            exp_v = (m_lfsr[1:0] < 2'd3) && (m_lfsr[3:2] < 2'd3);
            chk($sformatf("rnd%0d_v", cyc), {31'd0, v3}, {31'd0, exp_v});
            chk($sformatf("rnd%0d_sent", cyc), {16'd0, sent3}, m_count);
            if (exp_v) begin
                pay = 4'(m_count) ^ 4'd5;
                chk($sformatf("rnd%0d_data", cyc), {24'd0, data3}, {24'd0, pay, m_lfsr[3:0]});
            end
            if (v3)
                chk($sformatf("rnd%0d_dest_range", cyc),
                    {31'd0, (data3[1:0] <= 2'd2) && (data3[3:2] <= 2'd2)}, 32'd1);
            rdy = ($urandom_range(0, 3) != 0);
            ready3 = rdy;
            if (exp_v && rdy) begin
                m_count++;
                m_lfsr = ref_step(m_lfsr);
            end else if (!exp_v) begin
                bubbles++;
                m_lfsr = ref_step(m_lfsr);
            end
            cyc++;
            @(negedge clk);
        end
        chk("rnd_finished_in_budget", {31'd0, (m_count == 100)}, 32'd1);
        chk("rnd_bubbles_seen", {31'd0, (bubbles > 0)}, 32'd1);
        chk("rnd_done", {31'd0, done3}, 32'd1);
        chk("rnd_busy", {31'd0, busy3}, 32'd0);
        chk("rnd_v_after", {31'd0, v3}, 32'd0);
        chk("rnd_sent", {16'd0, sent3}, 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
